// File: rtl/uart_rx_mm.sv
`default_nettype none
// ============================================================================
// uart_rx_mm : memory-mapped 8N1 UART receiver with receive FIFO and registered read port
// Revision   : 1.0
// ============================================================================
module uart_rx_mm #(
   parameter int DW        = 32,
   parameter int DEPTH     = 8,
   parameter int DIV_RESET = 868
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cs_i,
   input  logic          we_i,
   input  logic [1:0]    addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   input  logic          rx_i,
   output logic          irq_o
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t             state_q;
   logic [15:0]        cnt_q;
   logic [15:0]        div_l_q;
   logic [15:0]        baud_q;
   logic [2:0]         bit_idx_q;
   logic [7:0]         shreg_q;
   logic               rx_meta_q;
   logic               rx_s_q;
   logic               rx_p_q;

   logic [7:0]         mem_q [DEPTH];
   logic [c_PTR_W-1:0] wr_ptr_q;
   logic [c_PTR_W-1:0] rd_ptr_q;
   logic [c_CNT_W-1:0] count_q;
   logic [c_CNT_W-1:0] count_d;
   logic               overrun_q;
   logic               frame_err_q;
   logic               irq_q;
   logic [DW-1:0]      rdata_q;

   logic               w_sample;
   logic               w_push_req;
   logic               w_frame_bad;
   logic               w_rd;
   logic               w_wr;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_push;
   logic [15:0]        w_div_wr;
   logic [DW-1:0]      w_rdata;

   assign w_sample    = (cnt_q == 16'd0);
   assign w_push_req  = (state_q == S_STOP) && w_sample && rx_s_q;
   assign w_frame_bad = (state_q == S_STOP) && w_sample && !rx_s_q;
   assign w_rd        = cs_i && !we_i;
   assign w_wr        = cs_i && we_i;
   assign w_full      = (count_q == c_FULL);
   assign w_empty     = (count_q == '0);
   assign w_pop       = w_rd && (addr_i == 2'd0) && !w_empty;
   // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
   assign w_push      = w_push_req && (!w_full || w_pop);
   assign w_div_wr    = (wdata_i[15:0] < 16'd4) ? 16'd4 : wdata_i[15:0];

   always_comb begin
      count_d = count_q;
      if (w_push && !w_pop) begin
         count_d = count_q + c_CNT_W'(1);
      end else if (!w_push && w_pop) begin
         count_d = count_q - c_CNT_W'(1);
      end
   end

   always_comb begin
      w_rdata = '0;
      case (addr_i)
         2'd0: begin
            if (!w_empty) begin
               w_rdata[DW-1] = 1'b1;
               w_rdata[7:0]  = mem_q[rd_ptr_q];
            end
         end
         2'd1: begin
            w_rdata[c_CNT_W+3:4] = count_q;
            w_rdata[3]           = frame_err_q;
            w_rdata[2]           = overrun_q;
            w_rdata[1]           = w_full;
            w_rdata[0]           = !w_empty;
         end
         2'd2: begin
            w_rdata[15:0] = baud_q;
         end
         default: begin
            w_rdata = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_p_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
         rx_p_q    <= rx_s_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div_l_q   <= 16'(DIV_RESET);
         bit_idx_q <= '0;
         shreg_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rx_p_q && !rx_s_q) begin
                  div_l_q <= baud_q;
                  cnt_q   <= baud_q >> 1;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (!w_sample) begin
                  cnt_q <= cnt_q - 16'd1;
               end else if (!rx_s_q) begin
                  cnt_q     <= div_l_q - 16'd1;
                  bit_idx_q <= '0;
                  state_q   <= S_DATA;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_DATA: begin
               if (!w_sample) begin
                  cnt_q <= cnt_q - 16'd1;
               end else begin
                  shreg_q   <= {rx_s_q, shreg_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  cnt_q     <= div_l_q - 16'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (!w_sample) begin
                  cnt_q <= cnt_q - 16'd1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= shreg_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         irq_q       <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rdata_q     <= '0;
         baud_q      <= 16'(DIV_RESET);
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
         end
         count_q <= count_d;
         irq_q   <= (count_d != '0);

         // Hardware set has priority over a write-1-to-clear in the same cycle.
         if (w_push_req && !w_push) begin
            overrun_q <= 1'b1;
         end else if (w_wr && (addr_i == 2'd1) && wdata_i[2]) begin
            overrun_q <= 1'b0;
         end
         if (w_frame_bad) begin
            frame_err_q <= 1'b1;
         end else if (w_wr && (addr_i == 2'd1) && wdata_i[3]) begin
            frame_err_q <= 1'b0;
         end

         if (w_rd) begin
            rdata_q <= w_rdata;
         end
         if (w_wr && (addr_i == 2'd2)) begin
            baud_q <= w_div_wr;
         end
      end
   end

   assign rdata_o = rdata_q;
   assign irq_o   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mm.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_mm : randomized self-checking bench with a queue-based receiver model
// Revision      : 1.0
// ============================================================================
module tb_uart_rx_mm;

   localparam int DW        = 32;
   localparam int DEPTH     = 8;
   localparam int DIV_RESET = 868;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          cs_i;
   logic          we_i;
   logic [1:0]    addr_i;
   logic [DW-1:0] wdata_i;
   logic [DW-1:0] rdata_o;
   logic          rx_i;
   logic          irq_o;

   uart_rx_mm #(
      .DW        (DW),
      .DEPTH     (DEPTH),
      .DIV_RESET (DIV_RESET)
   ) u_dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cs_i    (cs_i),
      .we_i    (we_i),
      .addr_i  (addr_i),
      .wdata_i (wdata_i),
      .rdata_o (rdata_o),
      .rx_i    (rx_i),
      .irq_o   (irq_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   logic [7:0] mq[$];
   bit         m_ovr;
   bit         m_ferr;
   int         m_div;
   logic [31:0] m_last_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovr     = 1'b0;
      m_ferr    = 1'b0;
      m_div     = DIV_RESET;
      m_last_rd = '0;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok)                m_ferr = 1'b1;
      else if (mq.size() < DEPTH)  mq.push_back(b);
      else                         m_ovr = 1'b1;
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s      = '0;
      s[7:4] = 4'(mq.size());
      s[3]   = m_ferr;
      s[2]   = m_ovr;
      s[1]   = (mq.size() == DEPTH);
      s[0]   = (mq.size() != 0);
      return s;
   endfunction

   task automatic exp_rxdata(output logic [31:0] e);
      if (mq.size() == 0) e = '0;
      else                e = {1'b1, 23'b0, mq.pop_front()};
   endtask

   // All bus tasks are entered just after a falling edge.
   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      cs_i   = 1'b1;
      we_i   = 1'b0;
      addr_i = a;
      @(posedge clk_i);
      @(negedge clk_i);
      cs_i = 1'b0;
      d    = rdata_o;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      cs_i    = 1'b1;
      we_i    = 1'b1;
      addr_i  = a;
      wdata_i = d;
      @(posedge clk_i);
      @(negedge clk_i);
      cs_i = 1'b0;
      we_i = 1'b0;
      if (a == 2'd1) begin
         if (d[2]) m_ovr  = 1'b0;
         if (d[3]) m_ferr = 1'b0;
      end else if (a == 2'd2) begin
         m_div = (d[15:0] < 16'd4) ? 4 : int'(d[15:0]);
      end
   endtask

   task automatic rd_check(input string tag, input logic [1:0] a);
      logic [31:0] d;
      logic [31:0] e;
      case (a)
         2'd0:    exp_rxdata(e);
         2'd1:    e = exp_status();
         2'd2:    e = 32'(m_div);
         default: e = '0;
      endcase
      bus_read(a, d);
      m_last_rd = e;
      check(tag, d, e);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_bit, input int div);
      rx_i = 1'b0;
      repeat (div) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (div) @(negedge clk_i);
      end
      rx_i = stop_bit;
      repeat (div) @(negedge clk_i);
      rx_i = 1'b1;
   endtask

   task automatic frame(input logic [7:0] b, input bit stop_ok);
      send_byte(b, stop_ok, m_div);
      repeat (8) @(negedge clk_i);
      model_frame(b, stop_ok);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] e;
      logic [7:0]  b;
      int          n;

      rst_i   = 1'b1;
      cs_i    = 1'b0;
      we_i    = 1'b0;
      addr_i  = '0;
      wdata_i = '0;
      rx_i    = 1'b1;
      model_reset();
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (100) @(negedge clk_i);

      check("rst_rdata", rdata_o, 32'h0);
      check("rst_irq", 32'(irq_o), 32'h0);
      rd_check("rst_status", 2'd1);
      rd_check("rst_baud", 2'd2);

      // Single byte, irq timing around the stop-bit sample
      bus_write(2'd2, 32'd16);
      fork
         send_byte(8'hA5, 1'b1, 16);
         begin
            repeat (154) @(negedge clk_i);
            check("irq_before_stop", 32'(irq_o), 32'h0);
            repeat (4) @(negedge clk_i);
            check("irq_after_stop", 32'(irq_o), 32'h1);
         end
      join
      repeat (8) @(negedge clk_i);
      model_frame(8'hA5, 1'b1);
      rd_check("one_status", 2'd1);
      repeat (5) @(negedge clk_i);
      check("rdata_hold", rdata_o, m_last_rd);
      rd_check("one_rxdata", 2'd0);
      rd_check("one_rxdata_empty", 2'd0);

      // Overrun
      for (int i = 1; i <= 9; i++) frame(8'(i), 1'b1);
      rd_check("ovr_status", 2'd1);
      for (int i = 0; i < 9; i++) rd_check($sformatf("ovr_rd%0d", i), 2'd0);
      bus_write(2'd1, 32'h4);
      rd_check("ovr_cleared", 2'd1);

      // Frame error, then a short glitch
      frame(8'h3C, 1'b0);
      rd_check("ferr_status", 2'd1);
      rx_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (40) @(negedge clk_i);
      rd_check("glitch_status", 2'd1);
      check("glitch_irq", 32'(irq_o), 32'h0);
      bus_write(2'd1, 32'h8);
      rd_check("ferr_cleared", 2'd1);

      // Pop coinciding with the stop sample of a byte arriving at a full FIFO
      for (int i = 0; i < DEPTH; i++) frame(8'($urandom), 1'b1);
      exp_rxdata(e);
      fork
         send_byte(8'h55, 1'b1, 16);
         begin
            repeat (155) @(negedge clk_i);
            bus_read(2'd0, d);
         end
      join
      check("simul_rd", d, e);
      repeat (8) @(negedge clk_i);
      model_frame(8'h55, 1'b1);
      rd_check("simul_status", 2'd1);
      for (int i = 0; i < DEPTH; i++) rd_check($sformatf("simul_drain%0d", i), 2'd0);

      // Divisor clamp
      bus_write(2'd2, 32'd1);
      rd_check("clamp_baud", 2'd2);
      frame(8'hC3, 1'b1);
      rd_check("clamp_rxdata", 2'd0);

      // Randomized traffic
      for (int k = 0; k < 25; k++) begin
         if ($urandom_range(3, 0) == 0) bus_write(2'd2, 32'($urandom_range(24, 0)));
         b = 8'($urandom);
         frame(b, $urandom_range(7, 0) != 0);
         check($sformatf("rnd_irq%0d", k), 32'(irq_o), 32'(mq.size() != 0));
         n = $urandom_range(3, 0);
         for (int j = 0; j < n; j++) begin
            rd_check($sformatf("rnd_rd%0d_%0d", k, j), 2'($urandom_range(3, 0)));
         end
         if ($urandom_range(3, 0) == 0) begin
            bus_write(2'($urandom_range(1, 0) == 0 ? 1 : $urandom_range(3, 0)), $urandom);
            rd_check($sformatf("rnd_wst%0d", k), 2'd1);
         end
      end

      // Reset in the middle of a frame
      bus_write(2'd2, 32'd16);
      frame(8'h77, 1'b1);
      rx_i = 1'b0;
      repeat (16) @(negedge clk_i);
      b = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         rx_i = b[i];
         repeat (16) @(negedge clk_i);
      end
      rx_i = b[3];
      repeat (8) @(negedge clk_i);
      rst_i = 1'b1;
      rx_i  = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      model_reset();
      repeat (200) @(negedge clk_i);
      check("mid_rst_rdata", rdata_o, 32'h0);
      check("mid_rst_irq", 32'(irq_o), 32'h0);
      rd_check("mid_rst_status", 2'd1);
      rd_check("mid_rst_baud", 2'd2);
      rd_check("mid_rst_rxdata", 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
